// File: rtl/dmx_1to2_stream_if.sv
// Bundle of the input stream and the two output streams of the 1-to-2 demux.
interface dmx_1to2_stream_if #(
    parameter int NB_INPUT = 32,
    parameter int NB_COUNT = 16
);
    logic [NB_INPUT-1:0] i_data;
    logic                i_sel;
    logic                i_valid;
    logic                o_ready;
    logic [NB_INPUT-1:0] o_a_data;
    logic                o_a_valid;
    logic                i_a_ready;
    logic [NB_INPUT-1:0] o_b_data;
    logic                o_b_valid;
    logic                i_b_ready;
    logic [NB_COUNT-1:0] o_a_count;
    logic [NB_COUNT-1:0] o_b_count;

    // Demux side
    modport slave (
        input  i_data, i_sel, i_valid, i_a_ready, i_b_ready,
        output o_ready, o_a_data, o_a_valid, o_b_data, o_b_valid, o_a_count, o_b_count
    );

    // Producer/consumer side
    modport master (
        output i_data, i_sel, i_valid, i_a_ready, i_b_ready,
        input  o_ready, o_a_data, o_a_valid, o_b_data, o_b_valid, o_a_count, o_b_count
    );
endinterface

// File: rtl/dmx_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer with one holding slot per output
// and a saturating transfer counter per output.
module dmx_1to2_stream #(
    parameter int NB_INPUT = 32,
    parameter int NB_COUNT = 16
) (
    input logic                   i_clk,
    input logic                   i_rst,
    dmx_1to2_stream_if.slave      bus
);
    logic [NB_INPUT-1:0] r_a_data;
    logic                r_a_valid;
    logic [NB_INPUT-1:0] r_b_data;
    logic                r_b_valid;
    logic [NB_COUNT-1:0] r_a_count;
    logic [NB_COUNT-1:0] r_b_count;

    logic w_free_a;
    logic w_free_b;
    logic w_ready;
    logic w_acc;
    logic w_load_a;
    logic w_load_b;
    logic w_hs_a;
    logic w_hs_b;

    // Slot availability, accept and handshake decode; i_valid never reaches o_ready
    always_comb begin
        w_free_a = ~r_a_valid | bus.i_a_ready;
        w_free_b = ~r_b_valid | bus.i_b_ready;
        w_ready  = bus.i_sel ? w_free_b : w_free_a;
        w_acc    = bus.i_valid & w_ready;
        w_load_a = w_acc & ~bus.i_sel;
        w_load_b = w_acc & bus.i_sel;
        w_hs_a   = r_a_valid & bus.i_a_ready;
        w_hs_b   = r_b_valid & bus.i_b_ready;
    end

    // Slot A: a load wins over a drain so back-to-back words keep valid high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_data  <= '0;
            r_a_valid <= 1'b0;
        end else if (w_load_a) begin
            r_a_data  <= bus.i_data;
            r_a_valid <= 1'b1;
        end else if (w_hs_a) begin
            r_a_valid <= 1'b0;
        end
    end

    // Slot B: same behaviour as slot A, fully independent
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_b_data  <= '0;
            r_b_valid <= 1'b0;
        end else if (w_load_b) begin
            r_b_data  <= bus.i_data;
            r_b_valid <= 1'b1;
        end else if (w_hs_b) begin
            r_b_valid <= 1'b0;
        end
    end

    // Saturating transfer counters, one per output handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_hs_a && (r_a_count != {NB_COUNT{1'b1}})) begin
                r_a_count <= r_a_count + NB_COUNT'(1);
            end
            if (w_hs_b && (r_b_count != {NB_COUNT{1'b1}})) begin
                r_b_count <= r_b_count + NB_COUNT'(1);
            end
        end
    end

    assign bus.o_ready   = w_ready;
    assign bus.o_a_data  = r_a_data;
    assign bus.o_a_valid = r_a_valid;
    assign bus.o_b_data  = r_b_data;
    assign bus.o_b_valid = r_b_valid;
    assign bus.o_a_count = r_a_count;
    assign bus.o_b_count = r_b_count;
endmodule

// File: doc/dmx_1to2_stream.md
# dmx_1to2_stream

Registered 1-to-2 stream demultiplexer: steers each accepted input word to output A or B according to a select bit captured with the word, with a valid/ready handshake on every port. It is the splitting counterpart of the 2-to-1 selection used in the datapath. It sits between a single producer, such as the debug/loader byte path, and two consumers, such as the instruction-memory loader and the command decoder. Each output has a one-entry holding register and a saturating transfer counter for debug visibility.

## Interface
- NB_INPUT, 32, width of the data word
- NB_COUNT, 16, width of each per-output transfer counter
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_data  in  NB_INPUT  input word
- i_sel  in  1  destination for i_data: 0 → A, 1 → B; qualified by i_valid
- i_valid  in  1  input word present
- o_ready  out  1  block accepts the input word this cycle
- o_a_data  out  NB_INPUT  output A word
- o_a_valid  out  1  output A holds a word
- i_a_ready  in  1  consumer A takes the word this cycle
- o_b_data  out  NB_INPUT  output B word
- o_b_valid  out  1  output B holds a word
- i_b_ready  in  1  consumer B takes the word this cycle
- o_a_count  out  NB_COUNT  completed A transfers, saturating
- o_b_count  out  NB_COUNT  completed B transfers, saturating

## Operation
- Each output X ∈ {A, B} has one slot: register data_X and flag valid_X, which drives o_X_valid.
- Slot X is free when ~valid_X | i_X_ready. This includes the case where the slot drains in the same cycle.
- o_ready = i_sel ? free_B : free_A. It is combinational on i_sel and the selected slot only. The non-selected output never stalls the input.
- Input accept (acc) = i_valid & o_ready. On acc, the selected slot loads i_data and sets valid.
- Output handshake X = o_X_valid & i_X_ready. If a handshake occurs and there is no load into that slot, valid_X clears.
- A load and a drain in the same cycle on the same slot: valid_X stays 1 and data_X takes the new word. This gives back-to-back throughput of one word per cycle.
- While o_X_valid=1 and i_X_ready=0, o_X_data and o_X_valid hold stable.
- data_X changes only on a load. The non-selected slot is never written.
- A and B operate independently. An A drain and a B load, or the reverse, in the same cycle both take effect.
- Counters: o_X_count increments by 1 on each output X handshake. At all-ones it holds; it never wraps.
- Order is preserved per output. There is no ordering guarantee between A and B.
- i_sel and i_data are ignored when i_valid=0.

## Timing
- Reset, i_rst=1 at a rising edge, sets:
  - o_a_valid = o_b_valid = 0
  - o_a_data = o_b_data = 0
  - both counters = 0
- During reset, o_ready follows the free equations, i.e. 1 once the valids are cleared.
- Reset mid-operation discards pending slot contents. No handshake is counted in the reset cycle.
- Latency: a word accepted at edge n is visible on o_X_data with o_X_valid=1 after edge n, and can be consumed in the cycle following edge n.
- Throughput: 1 word/cycle sustained to either output while its consumer holds ready=1.
- Combinational paths: i_sel, i_a_ready, i_b_ready → o_ready. There is no path from i_valid to o_ready.

## Test plan
- Reset: drive i_rst=1 for 2 cycles with random inputs → both valids 0, both data 0, both counts 0, o_ready=1 after release.
- Alternating stream, both consumers always ready:
  - Stimulus: 0x11(sel 0), 0x22(sel 1), 0x33(sel 0), 0x44(sel 1) on consecutive cycles.
  - Required: A outputs 0x11 then 0x33, B outputs 0x22 then 0x44, each 1 cycle after acceptance; final o_a_count=2, o_b_count=2.
- Backpressure isolation:
  - Stimulus: i_a_ready=0; send 0xAAAA(sel 0), then 0xBBBB(sel 1), then 0xCCCC(sel 0).
  - Required: A holds 0xAAAA stable; B delivers 0xBBBB; o_ready=0 while 0xCCCC is pending.
  - Then raise i_a_ready: 0xAAAA and 0xCCCC are delivered in consecutive cycles.
- Simultaneous load and drain: continuous sel=0 words 1..8 with i_a_ready=1 → o_ready stays 1, A valid stays 1, outputs are 1..8 on consecutive cycles, o_a_count=8.
- Counter saturation:
  - Stimulus: NB_COUNT=4; perform 20 B transfers.
  - Required: o_b_count reaches 15 and holds; o_a_count=0.
- Reset mid-operation: with o_a_valid=1 (0x5A) stalled and o_b_count=3, pulse i_rst for 1 cycle → o_a_valid=0, o_a_data=0, o_b_count=0; the stalled word is never delivered.
